// File: rtl/sts_detect_ctrl.sv
// STS detection sequencer: flushes and arms the sliding-window averagers, masks the warm-up,
// counts consecutive threshold hits, pulses on detection, then blanks the rest of the preamble.
module sts_detect_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int WIN_LEN      = 16,
  parameter int HIT_CNT      = 32,
  parameter int HOLDOFF      = 320,
  parameter int FLUSH_CYCLES = 2,
  localparam int HC_W        = $clog2(HIT_CNT + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [3:0]            thresh_num,
  input  logic [DATA_WIDTH-1:0] energy_min,
  input  logic                  metric_valid,
  input  logic [DATA_WIDTH-1:0] corr_mag,
  input  logic [DATA_WIDTH-1:0] energy,
  output logic                  avg_enable,
  output logic                  sts_detected,
  output logic                  det_busy,
  output logic [HC_W-1:0]       hit_count,
  output logic [2:0]            ctrl_state
);

  localparam int CNT_MAX_A = (WIN_LEN > HOLDOFF) ? WIN_LEN : HOLDOFF;
  localparam int CNT_MAX   = (CNT_MAX_A > FLUSH_CYCLES) ? CNT_MAX_A : FLUSH_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int PW        = DATA_WIDTH + 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FLUSH  = 3'd1,
    ARM    = 3'd2,
    SEARCH = 3'd3,
    HOLD   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [HC_W-1:0]       hc_q, hc_d;
  logic                  det_q, det_d;
  logic [3:0]            thr_q, thr_d;
  logic [DATA_WIDTH-1:0] emin_q, emin_d;
  logic                  hit;

  // corr*8 >= energy*(thr/8)*8; the 4 extra bits hold the full product so nothing wraps.
  function automatic logic ratio_hit(input logic [DATA_WIDTH-1:0] c,
                                     input logic [DATA_WIDTH-1:0] e,
                                     input logic [3:0]            t,
                                     input logic [DATA_WIDTH-1:0] emin);
    logic [PW-1:0] c_x8;
    logic [PW-1:0] e_t;
    c_x8 = {1'b0, c, 3'b000};
    e_t  = PW'(e) * PW'(t);
    return (c_x8 >= e_t) && (e >= emin);
  endfunction

  assign hit = ratio_hit(corr_mag, energy, thr_q, emin_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hc_q    <= '0;
      det_q   <= 1'b0;
      thr_q   <= '0;
      emin_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hc_q    <= hc_d;
      det_q   <= det_d;
      thr_q   <= thr_d;
      emin_q  <= emin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hc_d    = hc_q;
    det_d   = 1'b0;
    thr_d   = thr_q;
    emin_d  = emin_q;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      hc_d    = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = FLUSH;
          cnt_d   = '0;
        end
        FLUSH: begin
          // Squelch and ratio are frozen here so they stay stable for a whole detection pass.
          if (cnt_q == '0) begin
            thr_d  = thresh_num;
            emin_d = energy_min;
          end
          if (cnt_q == CNT_W'(FLUSH_CYCLES - 1)) begin
            state_d = ARM;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ARM: begin
          if (metric_valid) begin
            if (cnt_q == CNT_W'(WIN_LEN - 1)) begin
              state_d = SEARCH;
              cnt_d   = '0;
              hc_d    = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        SEARCH: begin
          if (metric_valid) begin
            if (!hit) begin
              hc_d = '0;
            end else if (hc_q == HC_W'(HIT_CNT - 1)) begin
              det_d   = 1'b1;
              state_d = HOLD;
              hc_d    = '0;
              cnt_d   = '0;
            end else begin
              hc_d = hc_q + HC_W'(1);
            end
          end
        end
        HOLD: begin
          if (metric_valid) begin
            if (cnt_q == CNT_W'(HOLDOFF - 1)) begin
              state_d = FLUSH;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          hc_d    = '0;
        end
      endcase
    end
  end

  assign avg_enable   = (state_q == ARM) || (state_q == SEARCH) || (state_q == HOLD);
  assign det_busy     = (state_q != IDLE);
  assign ctrl_state   = state_q;
  assign hit_count    = hc_q;
  assign sts_detected = det_q;

  // The pulse can only come from the SEARCH->HOLD step, so it always lands in HOLD for one cycle.
  a_det_single : assert property (@(posedge clk) disable iff (!rst_n)
                                  sts_detected |=> !sts_detected);
  a_det_in_hold : assert property (@(posedge clk) disable iff (!rst_n)
                                   sts_detected |-> (state_q == HOLD));

endmodule

// File: tb/tb_sts_detect_ctrl.sv
// Bench for sts_detect_ctrl: directed preamble scenarios, a hit-condition vector table and
// randomized traffic, all compared against a rule-level reference model.
module tb_sts_detect_ctrl;
  localparam int DW   = 32;
  localparam int WIN  = 16;
  localparam int HC   = 32;
  localparam int HOLD = 320;
  localparam int FL   = 2;
  localparam int HCW  = $clog2(HC + 1);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           enable = 1'b0;
  logic [3:0]     thresh_num = 4'd0;
  logic [DW-1:0]  energy_min = '0;
  logic           metric_valid = 1'b0;
  logic [DW-1:0]  corr_mag = '0;
  logic [DW-1:0]  energy = '0;
  logic           avg_enable, sts_detected, det_busy;
  logic [HCW-1:0] hit_count;
  logic [2:0]     ctrl_state;

  int errors = 0;
  int checks = 0;

  sts_detect_ctrl #(.DATA_WIDTH(DW), .WIN_LEN(WIN), .HIT_CNT(HC), .HOLDOFF(HOLD),
                    .FLUSH_CYCLES(FL)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .thresh_num(thresh_num),
    .energy_min(energy_min), .metric_valid(metric_valid), .corr_mag(corr_mag),
    .energy(energy), .avg_enable(avg_enable), .sts_detected(sts_detected),
    .det_busy(det_busy), .hit_count(hit_count), .ctrl_state(ctrl_state)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0..4 = idle, flush, arm, search, hold; 'remain' counts down what is left.
  typedef struct {
    int     phase;
    int     remain;
    int     hits;
    bit     det;
    int     thr;
    longint emin;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mstep(mdl_t cur, bit en, int tn, longint emn, bit mv,
                                 longint c, longint e);
    mdl_t n;
    bit   hit;
    n     = cur;
    n.det = 1'b0;
    hit   = (c * 8 >= e * cur.thr) && (e >= cur.emin);
    if (!en) begin
      n.phase  = 0;
      n.remain = 0;
      n.hits   = 0;
    end else begin
      case (cur.phase)
        0: begin n.phase = 1; n.remain = FL; end
        1: begin
          if (cur.remain == FL) begin n.thr = tn; n.emin = emn; end
          n.remain = cur.remain - 1;
          if (n.remain == 0) begin n.phase = 2; n.remain = WIN; end
        end
        2: if (mv) begin
          n.remain = cur.remain - 1;
          if (n.remain == 0) begin n.phase = 3; n.hits = 0; end
        end
        3: if (mv) begin
          if (!hit) n.hits = 0;
          else if (cur.hits + 1 == HC) begin
            n.det = 1'b1; n.phase = 4; n.hits = 0; n.remain = HOLD;
          end else n.hits = cur.hits + 1;
        end
        4: if (mv) begin
          n.remain = cur.remain - 1;
          if (n.remain == 0) begin n.phase = 1; n.remain = FL; end
        end
        default: n.phase = 0;
      endcase
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{default: 0};
    else m <= mstep(m, enable, int'(thresh_num), longint'(energy_min), metric_valid,
                    longint'(corr_mag), longint'(energy));
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    logic [11:0] act, exp;
    act = {ctrl_state, avg_enable, det_busy, hit_count, sts_detected};
    exp = {3'(m.phase), (m.phase >= 2), (m.phase != 0), 6'(m.hits), m.det};
    chk("model{state,avg,busy,hc,det}", longint'(act), longint'(exp));
  endtask

  task automatic tick();
    @(negedge clk);
    cmp_model();
  endtask

  task automatic beat(input logic [DW-1:0] c, input logic [DW-1:0] e);
    corr_mag     = c;
    energy       = e;
    metric_valid = 1'b1;
    tick();
  endtask

  task automatic run_beats(input int nb, input logic [DW-1:0] c, input logic [DW-1:0] e,
                           output int maxhc, output int dets);
    maxhc = 0;
    dets  = 0;
    for (int i = 0; i < nb; i++) begin
      beat(c, e);
      if (int'(hit_count) > maxhc) maxhc = int'(hit_count);
      if (sts_detected) dets++;
    end
  endtask

  task automatic wait_state(input int s, input int budget, input string name);
    int k;
    k = 0;
    while (int'(ctrl_state) != s && k < budget) begin
      tick();
      k++;
    end
    chk(name, longint'(ctrl_state), longint'(s));
  endtask

  typedef struct {
    logic [DW-1:0] c;
    logic [DW-1:0] e;
    logic          mv;
    int            exp_hc;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n, mx, d, mode;

    // Hit-condition vectors, applied in SEARCH with ratio 4/8 and squelch 1.
    tbl[0]  = '{32'd100, 32'd100, 1'b1, 1};
    tbl[1]  = '{32'd100, 32'd100, 1'b0, 1};
    tbl[2]  = '{32'd10, 32'd100, 1'b1, 0};
    tbl[3]  = '{32'd50, 32'd100, 1'b1, 1};
    tbl[4]  = '{32'd49, 32'd100, 1'b1, 0};
    tbl[5]  = '{32'd50, 32'd100, 1'b1, 1};
    tbl[6]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 2};
    tbl[7]  = '{32'd5, 32'd0, 1'b1, 0};
    tbl[8]  = '{32'd5, 32'd1, 1'b1, 1};
    tbl[9]  = '{32'd0, 32'd1, 1'b1, 0};
    tbl[10] = '{32'd1, 32'd2, 1'b1, 1};
    tbl[11] = '{32'h2000_0000, 32'h3FFF_FFFF, 1'b1, 2};

    #12;
    chk("rst_state", longint'(ctrl_state), 0);
    chk("rst_avg", longint'(avg_enable), 0);
    chk("rst_busy", longint'(det_busy), 0);
    chk("rst_hc", longint'(hit_count), 0);
    chk("rst_det", longint'(sts_detected), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Warm-up masking and detection latency.
    thresh_num = 4'd4; energy_min = 32'd1; corr_mag = 32'd100; energy = 32'd100;
    metric_valid = 1'b1; enable = 1'b1;
    tick();
    chk("flush1_state", longint'(ctrl_state), 1);
    chk("flush1_avg", longint'(avg_enable), 0);
    chk("flush1_busy", longint'(det_busy), 1);
    tick();
    chk("flush2_state", longint'(ctrl_state), 1);
    chk("flush2_avg", longint'(avg_enable), 0);
    tick();
    chk("arm_state", longint'(ctrl_state), 2);
    chk("arm_avg", longint'(avg_enable), 1);
    n = 0;
    do begin tick(); n++; end while (!sts_detected && n < 200);
    chk("warmup_latency", n, WIN + HC);
    tick();
    chk("det_one_cycle", longint'(sts_detected), 0);
    chk("hold_state", longint'(ctrl_state), 4);

    // Holdoff then re-arm.
    n = 1; d = 0;
    while (ctrl_state == 3'd4 && n < 400) begin
      tick(); n++;
      if (sts_detected) d++;
    end
    chk("holdoff_beats", n, HOLD);
    chk("hold_no_pulse", d, 0);
    chk("reflush1_state", longint'(ctrl_state), 1);
    chk("reflush1_avg", longint'(avg_enable), 0);
    tick();
    chk("reflush2_avg", longint'(avg_enable), 0);
    tick();
    chk("rearm_state", longint'(ctrl_state), 2);

    // Miss resets the count.
    run_beats(WIN, 32'd100, 32'd100, mx, d);
    chk("search_entry", longint'(ctrl_state), 3);
    chk("search_hc0", longint'(hit_count), 0);
    run_beats(HC - 1, 32'd100, 32'd100, mx, d);
    chk("pre_miss_hc", longint'(hit_count), HC - 1);
    chk("pre_miss_nodet", d, 0);
    beat(32'd10, 32'd100);
    chk("miss_clears_hc", longint'(hit_count), 0);
    run_beats(HC - 1, 32'd100, 32'd100, mx, d);
    chk("post_miss_nodet", d, 0);
    beat(32'd100, 32'd100);
    chk("post_miss_det", longint'(sts_detected), 1);

    // Threshold latching and mid-search abort.
    wait_state(2, 400, "latch_rearm");
    wait_state(3, 40, "latch_search");
    thresh_num = 4'd15;
    run_beats(20, 32'd100, 32'd100, mx, d);
    chk("old_ratio_hits", longint'(hit_count), 20);
    enable = 1'b0;
    tick();
    chk("abort_state", longint'(ctrl_state), 0);
    chk("abort_avg", longint'(avg_enable), 0);
    chk("abort_hc", longint'(hit_count), 0);
    chk("abort_busy", longint'(det_busy), 0);
    chk("abort_det", longint'(sts_detected), 0);
    enable = 1'b1;
    wait_state(3, 40, "newthr_search");
    run_beats(100, 32'd100, 32'd100, mx, d);
    chk("new_ratio_maxhc", mx, 0);
    chk("new_ratio_nodet", d, 0);

    // Squelch.
    enable = 1'b0; tick();
    thresh_num = 4'd4; energy_min = 32'd1; corr_mag = '0; energy = '0; enable = 1'b1;
    wait_state(3, 40, "squelch_search");
    run_beats(100, 32'd0, 32'd0, mx, d);
    chk("squelch_maxhc", mx, 0);
    chk("squelch_nodet", d, 0);
    enable = 1'b0; tick();
    energy_min = 32'd0; enable = 1'b1;
    wait_state(3, 40, "nosquelch_search");
    n = 0;
    do begin beat(32'd0, 32'd0); n++; end while (!sts_detected && n < 60);
    chk("nosquelch_det_beats", n, HC);

    // Asynchronous reset in HOLD.
    run_beats(5, 32'd0, 32'd0, mx, d);
    chk("pre_rst_hold", longint'(ctrl_state), 4);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", longint'(ctrl_state), 0);
    chk("arst_avg", longint'(avg_enable), 0);
    chk("arst_busy", longint'(det_busy), 0);
    chk("arst_hc", longint'(hit_count), 0);
    chk("arst_det", longint'(sts_detected), 0);
    thresh_num = 4'd4; energy_min = 32'd1; corr_mag = 32'd100; energy = 32'd100;
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table.
    wait_state(3, 40, "tbl_search");
    foreach (tbl[i]) begin
      corr_mag = tbl[i].c; energy = tbl[i].e; metric_valid = tbl[i].mv;
      tick();
      chk($sformatf("tbl_hc[%0d]", i), longint'(hit_count), tbl[i].exp_hc);
    end

    // Randomized traffic.
    mode = 0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (cyc % 256 == 0) begin
        mode       = ($urandom_range(0, 2) != 0) ? 1 : 0;
        thresh_num = 4'($urandom_range(0, 15));
        energy_min = $urandom_range(0, 50);
      end
      enable       = ($urandom_range(0, 299) != 0);
      metric_valid = ($urandom_range(0, 3) != 0);
      if (mode == 1) begin
        energy   = $urandom_range(1, 1000);
        corr_mag = energy * 2;
      end else begin
        energy   = $urandom_range(0, 300);
        corr_mag = $urandom_range(0, 300);
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sts_detect_ctrl.md
Name: sts_detect_ctrl

Overview:
- Sequences the short-training-sequence (STS) detection datapath of the 802.11a receiver.
- Drives the enable of the sliding-window averagers that produce the averaged autocorrelation magnitude and averaged energy.
- Ignores their metrics while the windows are filling, then declares STS detection after HIT_CNT consecutive threshold hits.
- After a detection, blanks the detector for the rest of the preamble, then flushes and re-arms the averagers.

Parameters:
- DATA_WIDTH, 32, width of corr_mag and energy metrics (unsigned).
- WIN_LEN, 16, averager window depth; number of warm-up metric_valid beats ignored after re-arm.
- HIT_CNT, 32, consecutive hits required to declare detection (>=1).
- HOLDOFF, 320, metric_valid beats blanked after detection.
- FLUSH_CYCLES, 2, clock cycles avg_enable is held low to clear the averagers (>=1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  block enable; low forces IDLE.
- thresh_num  in  4  threshold ratio numerator; the threshold is thresh_num/8.
- energy_min  in  DATA_WIDTH  minimum energy for a valid hit (squelch).
- metric_valid  in  1  corr_mag/energy valid (aligned averager outputs).
- corr_mag  in  DATA_WIDTH  averaged autocorrelation magnitude.
- energy  in  DATA_WIDTH  averaged energy.
- avg_enable  out  1  enable to both averagers.
- sts_detected  out  1  one-cycle detection pulse.
- det_busy  out  1  high when state != IDLE.
- hit_count  out  clog2(HIT_CNT+1)  current consecutive-hit count.
- ctrl_state  out  3  state code: IDLE=0, FLUSH=1, ARM=2, SEARCH=3, HOLD=4.

Behaviour:
- Reset (rst_n low, async):
  - State is IDLE.
  - All outputs are 0.
  - All counters and latched thresholds are 0.
- Hit condition (combinational, unsigned, computed in DATA_WIDTH+4 bits with no overflow):
  - hit = ({corr_mag,3'b0} >= energy*thresh_lat) AND (energy >= emin_lat).
  - thresh_num=0 makes hit depend on energy_min only.
- FSM (all transitions on clk; enable low in any state -> IDLE next cycle, avg_enable=0, counters cleared, no sts_detected):
  - IDLE: avg_enable=0. If enable=1 -> FLUSH.
  - FLUSH:
    - avg_enable=0 for exactly FLUSH_CYCLES cycles, counted by a cycle counter.
    - thresh_lat<=thresh_num and emin_lat<=energy_min on the first FLUSH cycle; these values are held until the next FLUSH.
    - Then -> ARM.
  - ARM:
    - avg_enable=1.
    - Counts metric_valid beats; metrics are ignored.
    - On the WIN_LEN-th beat -> SEARCH, with hit_count=0.
  - SEARCH:
    - avg_enable=1.
    - On metric_valid: hit -> hit_count+1; miss -> hit_count=0.
    - If hit and hit_count==HIT_CNT-1: next cycle sts_detected=1, state=HOLD, hit_count=0.
    - Cycles without metric_valid leave hit_count unchanged.
  - HOLD:
    - avg_enable=1; metrics are ignored.
    - Counts metric_valid beats.
    - On the HOLDOFF-th beat -> FLUSH (re-arm).
- Latency: sts_detected rises one cycle after the clock edge that samples the qualifying metric_valid.
- sts_detected is never high for more than 1 cycle and never asserts outside the SEARCH->HOLD transition.
- Threshold/squelch input changes take effect only at the next FLUSH.
- det_busy=1 in every state except IDLE.
- Counters saturate at their terminal compare and never wrap.

Test Plan:
- Warm-up masking:
  - Stimulus: enable=1, thresh_num=4, energy_min=1, metric_valid every cycle with corr_mag=100, energy=100.
  - Required: avg_enable low for 2 cycles after FLUSH entry. First 16 beats ignored in ARM. sts_detected pulses exactly 1 cycle after the 16+32=48th valid beat following ARM entry.
- Miss resets count:
  - Stimulus: in SEARCH, 31 hits, then 1 miss (corr_mag=10, energy=100), then 32 hits.
  - Required: no pulse after the first 31. hit_count returns to 0 on the miss. Pulse after the final 32nd hit.
- Squelch:
  - Stimulus: energy=0, corr_mag=0, energy_min=1 for 100 beats.
  - Required: hit_count stays 0, no sts_detected.
  - Stimulus: same with energy_min=0.
  - Required: detection occurs.
- Holdoff and re-arm:
  - Stimulus: after detection, continue hits for 320 beats.
  - Required: no second pulse during HOLD. FLUSH entered after beat 320, avg_enable low 2 cycles, ARM restarts.
- Mid-operation abort:
  - Stimulus: deassert enable in SEARCH with hit_count=20.
  - Required: next cycle ctrl_state=0, avg_enable=0, hit_count=0, det_busy=0, no pulse.
  - Stimulus: assert rst_n=0 asynchronously mid-HOLD.
  - Required: all outputs 0 immediately, without a clk edge.
- Threshold latching:
  - Stimulus: change thresh_num 4->15 during SEARCH, with corr_mag=100, energy=100.
  - Required: hits continue (old ratio 0.5 is still used) until the next FLUSH. After FLUSH, 800 >= 1500 is false, so no detection.
